// File: rtl/pool_lin_reader.sv
// Pooled-line consumer: captures 3-channel lines into a 2-deep ping-pong buffer and
// streams elements over valid/ready. Optional ReLU clamp on output: define POOL_RD_RELU_EN.
module pool_lin_reader #(
    parameter int DW   = 8,
    parameter int NPOS = 3,
    parameter int NROW = 3,
    localparam int PW  = (NPOS > 1) ? $clog2(NPOS) : 1,
    localparam int RW  = (NROW > 1) ? $clog2(NROW) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lin_vld,
    input  logic [NPOS*DW-1:0] lin_D1,
    input  logic [NPOS*DW-1:0] lin_D2,
    input  logic [NPOS*DW-1:0] lin_D3,
    output logic               lin_rdy,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [DW-1:0]      out_data,
    output logic [1:0]         out_ch,
    output logic [PW-1:0]      out_pos,
    output logic [RW-1:0]      out_row,
    output logic               out_last,
    output logic               ovf_err
);

    localparam int LW = 3 * NPOS * DW;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // Line image is {D3,D2,D1}, so element (ch,pos) sits at index ch*NPOS+pos.
    logic [LW-1:0] mem_q [2];
    logic [LW-1:0] in_line;
    logic [LW-1:0] next_line;

    state_t          state_q, state_d;
    logic [1:0]      count_q, count_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [RW-1:0]   row_q, row_d;
    logic [RW-1:0]   row_inc;
    logic            out_vld_q, out_vld_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [1:0]      out_ch_q, out_ch_d;
    logic [PW-1:0]   out_pos_q, out_pos_d;
    logic [RW-1:0]   out_row_q, out_row_d;
    logic            out_last_q, out_last_d;
    logic            ovf_q, ovf_d;

    logic            wr_en;
    logic            accept;
    logic            line_done;
    logic            load_en;
    logic [LW-1:0]   load_line;
    logic [1:0]      load_ch;
    logic [PW-1:0]   load_pos;
    logic [RW-1:0]   load_row;

    function automatic logic [DW-1:0] pick(input logic [LW-1:0] line,
                                           input logic [1:0]    ch,
                                           input logic [PW-1:0] pos);
        logic [DW-1:0] v;
        v = line[(int'(ch) * NPOS + int'(pos)) * DW +: DW];
`ifdef POOL_RD_RELU_EN
        if (v[DW-1]) begin
            v = '0;
        end
`endif
        return v;
    endfunction

    assign in_line   = {lin_D3, lin_D2, lin_D1};
    assign wr_en     = lin_vld && (count_q != 2'd2);
    assign accept    = out_vld_q && out_rdy;
    assign row_inc   = (row_q == RW'(NROW - 1)) ? '0 : row_q + RW'(1);
    // With one line left, the follower is either already stored or arriving right now.
    assign next_line = (count_q == 2'd2) ? mem_q[~rd_ptr_q] : in_line;

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        row_d      = row_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        out_pos_d  = out_pos_q;
        out_row_d  = out_row_q;
        out_last_d = out_last_q;
        line_done  = 1'b0;
        load_en    = 1'b0;
        load_line  = mem_q[rd_ptr_q];
        load_ch    = 2'd0;
        load_pos   = '0;
        load_row   = row_q;

        case (state_q)
            IDLE: begin
                if (count_q != 2'd0 || wr_en) begin
                    load_en   = 1'b1;
                    load_line = (count_q != 2'd0) ? mem_q[rd_ptr_q] : in_line;
                end
            end
            STREAM: begin
                if (accept) begin
                    if (out_pos_q == PW'(NPOS - 1)) begin
                        if (out_ch_q == 2'd2) begin
                            line_done = 1'b1;
                        end else begin
                            load_en = 1'b1;
                            load_ch = out_ch_q + 2'd1;
                        end
                    end else begin
                        load_en  = 1'b1;
                        load_ch  = out_ch_q;
                        load_pos = out_pos_q + PW'(1);
                    end
                end
                if (line_done) begin
                    rd_ptr_d = ~rd_ptr_q;
                    row_d    = row_inc;
                    if (count_q == 2'd2 || wr_en) begin
                        load_en   = 1'b1;
                        load_line = next_line;
                        load_row  = row_inc;
                    end else begin
                        out_vld_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_en) begin
            state_d    = STREAM;
            out_vld_d  = 1'b1;
            out_data_d = pick(load_line, load_ch, load_pos);
            out_ch_d   = load_ch;
            out_pos_d  = load_pos;
            out_row_d  = load_row;
            out_last_d = (load_row == RW'(NROW - 1)) && (load_ch == 2'd2) &&
                         (load_pos == PW'(NPOS - 1));
        end
    end

    always_comb begin
        count_d  = count_q + {1'b0, wr_en} - {1'b0, line_done};
        wr_ptr_d = wr_ptr_q ^ wr_en;
        ovf_d    = ovf_q | (lin_vld && (count_q == 2'd2));
    end

    // Buffer storage carries no reset so it maps onto plain RAM/registers without a reset net.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_line;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            row_q      <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_ch_q   <= 2'd0;
            out_pos_q  <= '0;
            out_row_q  <= '0;
            out_last_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            row_q      <= row_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            out_pos_q  <= out_pos_d;
            out_row_q  <= out_row_d;
            out_last_q <= out_last_d;
            ovf_q      <= ovf_d;
        end
    end

    assign lin_rdy  = (count_q != 2'd2);
    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_ch   = out_ch_q;
    assign out_pos  = out_pos_q;
    assign out_row  = out_row_q;
    assign out_last = out_last_q;
    assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_pool_lin_reader.sv
// Self-checking bench for pool_lin_reader: vector table, directed corner sequences,
// and randomized traffic against a line-queue reference model.
module tb_pool_lin_reader;
    localparam int DW   = 8;
    localparam int NPOS = 3;
    localparam int NROW = 3;
    localparam int NEL  = 3 * NPOS;

    logic        clk = 1'b0;
    logic        rst;
    logic        lin_vld;
    logic [23:0] lin_D1, lin_D2, lin_D3;
    logic        lin_rdy;
    logic        out_vld;
    logic        out_rdy;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic [1:0]  out_pos;
    logic [1:0]  out_row;
    logic        out_last;
    logic        ovf_err;

    pool_lin_reader #(.DW(DW), .NPOS(NPOS), .NROW(NROW)) dut (
        .clk(clk), .rst(rst), .lin_vld(lin_vld),
        .lin_D1(lin_D1), .lin_D2(lin_D2), .lin_D3(lin_D3), .lin_rdy(lin_rdy),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .out_ch(out_ch), .out_pos(out_pos), .out_row(out_row),
        .out_last(out_last), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         ch;
        int         pos;
        int         row;
        bit         last;
    } elem_t;

    typedef struct {
        logic [23:0] d1;
        logic [23:0] d2;
        logic [23:0] d3;
        logic [71:0] exp_bytes;
    } vec_t;

    elem_t expq[$];
    int    mcount, mrow, mcons;
    bit    movf;
    int    n_cmp, n_bad;

    bit         s_vld, s_lin_rdy, s_ovf, s_hs, s_last;
    logic [7:0] s_data;
    int         s_ch, s_pos, s_row;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        expq.delete();
        mcount = 0;
        mrow   = 0;
        mcons  = 0;
        movf   = 1'b0;
    endtask

    task automatic model_push(input logic [23:0] d1, input logic [23:0] d2, input logic [23:0] d3);
        logic [23:0] ln;
        elem_t       e;
        for (int c = 0; c < 3; c++) begin
            ln = (c == 0) ? d1 : (c == 1) ? d2 : d3;
            for (int p = 0; p < NPOS; p++) begin
                e.data = ln[p*DW +: DW];
`ifdef POOL_RD_RELU_EN
                if (e.data[DW-1]) e.data = '0;
`endif
                e.ch   = c;
                e.pos  = p;
                e.row  = mrow;
                e.last = (mrow == NROW - 1) && (c == 2) && (p == NPOS - 1);
                expq.push_back(e);
            end
        end
        mrow = (mrow + 1) % NROW;
    endtask

    // One clock: drive at negedge, sample and check just after, then advance the model
    // to the state the coming rising edge should produce.
    task automatic cycle(input bit vld, input logic [23:0] d1, input logic [23:0] d2,
                         input logic [23:0] d3, input bit rdy);
        elem_t e;
        int    c0;
        @(negedge clk);
        lin_vld = vld;
        lin_D1  = d1;
        lin_D2  = d2;
        lin_D3  = d3;
        out_rdy = rdy;
        #1;
        s_vld     = out_vld;
        s_lin_rdy = lin_rdy;
        s_ovf     = ovf_err;
        s_data    = out_data;
        s_ch      = int'(out_ch);
        s_pos     = int'(out_pos);
        s_row     = int'(out_row);
        s_last    = out_last;
        s_hs      = out_vld && rdy;
        chk("lin_rdy", int'(s_lin_rdy), int'(mcount < 2));
        chk("out_vld", int'(s_vld), int'(mcount > 0));
        chk("ovf_err", int'(s_ovf), int'(movf));
        c0 = mcount;
        if (s_hs) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_elem: got data %0h expected none", s_data);
            end else begin
                e = expq.pop_front();
                chk("data", int'(s_data), int'(e.data));
                chk("ch", s_ch, e.ch);
                chk("pos", s_pos, e.pos);
                chk("row", s_row, e.row);
                chk("last", int'(s_last), int'(e.last));
                mcons++;
                if (mcons == NEL) begin
                    mcons = 0;
                    mcount--;
                end
            end
        end
        if (vld) begin
            if (c0 < 2) begin
                model_push(d1, d2, d3);
                mcount++;
            end else begin
                movf = 1'b1;
            end
        end
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 24'h0, 24'h0, 24'h0, rdy);
    endtask

    // Reset is raised between edges so the asynchronous clear is observed before any clock.
    task automatic do_reset();
        @(negedge clk);
        lin_vld = 1'b0;
        out_rdy = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        chk("rst_out_vld", int'(out_vld), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_ch_pos_row", int'({out_ch, out_pos, out_row}), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_ovf_err", int'(ovf_err), 0);
        chk("rst_lin_rdy", int'(lin_rdy), 1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs[2];

    initial begin
        int          hs;
        logic [7:0]  hold_data;
        int          hold_ch, hold_pos;
        logic [23:0] r1, r2, r3;

        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        lin_vld = 1'b0;
        lin_D1 = '0;
        lin_D2 = '0;
        lin_D3 = '0;
        out_rdy = 1'b0;
        model_clear();

        vecs[0] = '{d1: 24'h030201, d2: 24'h060504, d3: 24'h090807,
                    exp_bytes: 72'h09_08_07_06_05_04_03_02_01};
`ifdef POOL_RD_RELU_EN
        vecs[1] = '{d1: 24'h7F80FF, d2: 24'h00FF01, d3: 24'h8001FE,
                    exp_bytes: 72'h00_01_00_00_00_01_7F_00_00};
`else
        vecs[1] = '{d1: 24'h7F80FF, d2: 24'h00FF01, d3: 24'h8001FE,
                    exp_bytes: 72'h80_01_FE_00_FF_01_7F_80_FF};
`endif

        // Single line, continuous accept: element order, tags and one-cycle latency.
        for (int v = 0; v < 2; v++) begin
            do_reset();
            cycle(1'b1, vecs[v].d1, vecs[v].d2, vecs[v].d3, 1'b1);
            for (int i = 0; i < NEL; i++) begin
                idle(1'b1);
                chk("tbl_vld", int'(s_vld), 1);
                chk("tbl_data", int'(s_data), int'(vecs[v].exp_bytes[i*8 +: 8]));
                chk("tbl_ch", s_ch, i / NPOS);
                chk("tbl_pos", s_pos, i % NPOS);
                chk("tbl_row_last", s_row * 2 + int'(s_last), 0);
                chk("tbl_lin_rdy", int'(s_lin_rdy), 1);
            end
            idle(1'b1);
            chk("tbl_end_vld", int'(s_vld), 0);
        end

        // Overflow: third back-to-back line is dropped, then 18 elements drain gap-free.
        do_reset();
        cycle(1'b1, 24'h112233, 24'h445566, 24'h778899, 1'b0);
        chk("ovf_rdy0", int'(s_lin_rdy), 1);
        cycle(1'b1, 24'hA1A2A3, 24'hB1B2B3, 24'hC1C2C3, 1'b0);
        chk("ovf_rdy1", int'(s_lin_rdy), 1);
        cycle(1'b1, 24'hDEADBE, 24'hEF0102, 24'h030405, 1'b0);
        chk("ovf_rdy2", int'(s_lin_rdy), 0);
        hs = 0;
        for (int i = 0; i < 2 * NEL; i++) begin
            idle(1'b1);
            if (i == 0) chk("ovf_set", int'(s_ovf), 1);
            if (s_hs) hs++;
        end
        chk("ovf_drain_count", hs, 2 * NEL);
        idle(1'b1);
        chk("ovf_drain_end", int'(s_vld), 0);
        chk("ovf_sticky", int'(s_ovf), 1);

        // Full frame plus one line: out_last only on element 27, row wraps to 0.
        do_reset();
        hs = 0;
        for (int l = 0; l < NROW + 1; l++) begin
            cycle(1'b1, $urandom, $urandom, $urandom, 1'b1);
            for (int i = 0; i < NEL; i++) begin
                idle(1'b1);
                if (s_hs) begin
                    hs++;
                    chk("frame_last", int'(s_last), int'(hs == NROW * NEL));
                    if (hs == NROW * NEL + 1) chk("frame_row_wrap", s_row, 0);
                end
            end
        end
        chk("frame_count", hs, (NROW + 1) * NEL);

        // Stall mid-line: outputs frozen while out_rdy is low.
        do_reset();
        cycle(1'b1, 24'h302010, 24'h605040, 24'h908070, 1'b1);
        idle(1'b1);
        idle(1'b0);
        hold_data = s_data;
        hold_ch   = s_ch;
        hold_pos  = s_pos;
        idle(1'b0);
        chk("stall_data", int'(s_data), int'(hold_data));
        chk("stall_tag", s_ch * 4 + s_pos, hold_ch * 4 + hold_pos);
        for (int i = 0; i < NEL; i++) idle(1'b1);
        chk("stall_drained", int'(s_vld), 0);

        // Reset mid-stream with two lines buffered, then a fresh line starts at the origin.
        do_reset();
        cycle(1'b1, 24'h0A0B0C, 24'h0D0E0F, 24'h101112, 1'b0);
        cycle(1'b1, 24'h131415, 24'h161718, 24'h191A1B, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        do_reset();
        cycle(1'b1, 24'h5A5B5C, 24'h5D5E5F, 24'h606162, 1'b0);
        idle(1'b1);
        chk("post_rst_tag", s_row * 16 + s_ch * 4 + s_pos, 0);
        chk("post_rst_data", int'(s_data), 8'h5C);
        for (int i = 0; i < NEL; i++) idle(1'b1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            r3 = $urandom;
            cycle(($urandom_range(0, 2) == 0), r1, r2, r3, ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 2 * NEL + 2; i++) idle(1'b1);
        chk("rand_queue_empty", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
